// File: rtl/timer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// timer_pkg: shared state codes, register map and CTRL field positions | Rev 1.0
// ----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CNT  = 2'b10,
        INT  = 2'b11
    } state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_PSC_LSB  = 4;
    localparam int STAT_PEND_BIT = 0;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// timer_channel: one countdown channel with prescaler, FSM and W1C status | Rev 1.0
// ----------------------------------------------------------------------------
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [1:0]  sel_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam int CTRL_W = CTRL_PSC_LSB + PSC_W;

    state_e             state_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic [CNT_W-1:0]   preset_q;
    logic [CNT_W-1:0]   count_q;
    logic               pend_q;
    logic [PSC_W-1:0]   psc_cnt_q;

    logic               en;
    logic [1:0]         mode;
    logic [PSC_W-1:0]   psc;
    logic               unused_wdata;

    assign en           = ctrl_q[CTRL_EN_BIT];
    assign mode         = ctrl_q[CTRL_MODE_LSB +: 2];
    assign psc          = ctrl_q[CTRL_PSC_LSB +: PSC_W];
    assign irq_o        = pend_q & ctrl_q[CTRL_IM_BIT];
    assign unused_wdata = ^wdata_i;

    // A bus write to this channel freezes its FSM and prescaler for that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pend_q    <= 1'b0;
            psc_cnt_q <= '0;
        end else if (we_i) begin
            case (sel_i)
                REG_CTRL:   ctrl_q   <= wdata_i[CTRL_W-1:0];
                REG_PRESET: preset_q <= wdata_i[CNT_W-1:0];
                REG_COUNT:  count_q  <= wdata_i[CNT_W-1:0];
                REG_STATUS: if (wdata_i[STAT_PEND_BIT]) pend_q <= 1'b0;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q   <= LOAD;
                        pend_q    <= 1'b0;
                        psc_cnt_q <= '0;
                    end
                end
                LOAD: begin
                    count_q <= preset_q;
                    state_q <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (psc_cnt_q == psc) begin
                        psc_cnt_q <= '0;
                        if (count_q > CNT_W'(1)) begin
                            count_q <= count_q - CNT_W'(1);
                        end else begin
                            count_q <= '0;
                            pend_q  <= 1'b1;
                            state_q <= INT;
                        end
                    end else begin
                        psc_cnt_q <= psc_cnt_q + PSC_W'(1);
                    end
                end
                INT: begin
                    // en cleared by software while in INT must not restart a reload
                    if (en && mode == MODE_RELOAD) begin
                        state_q <= LOAD;
                    end else begin
                        ctrl_q[CTRL_EN_BIT] <= 1'b0;
                        state_q             <= IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rdata_o = '0;
        case (sel_i)
            REG_CTRL:   rdata_o[CTRL_W-1:0]    = ctrl_q;
            REG_PRESET: rdata_o[CNT_W-1:0]     = preset_q;
            REG_COUNT:  rdata_o[CNT_W-1:0]     = count_q;
            REG_STATUS: rdata_o[STAT_PEND_BIT] = pend_q;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multi_timer: N-channel MMIO countdown timer, address decode and IRQ merge | Rev 1.0
// ----------------------------------------------------------------------------
module multi_timer
    import timer_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    output logic            IRQ,
    output logic [N_CH-1:0] irq_vec
);

    logic [2:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic [31:0] ch_rdata [8];
    logic        unused_addr;

    assign ch_sel      = Addr[6:4];
    assign reg_sel     = Addr[3:2];
    assign unused_addr = ^Addr[31:7];

    // Unpopulated channel slots read as zero and never see a write strobe.
    for (genvar i = 0; i < 8; i++) begin : g_ch
        if (i < N_CH) begin : g_live
            timer_channel #(
                .CNT_W (CNT_W),
                .PSC_W (PSC_W)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .we_i    (WE && (ch_sel == 3'(i))),
                .sel_i   (reg_sel),
                .wdata_i (Din),
                .rdata_o (ch_rdata[i]),
                .irq_o   (irq_vec[i])
            );
        end else begin : g_absent
            assign ch_rdata[i] = '0;
        end
    end

    assign Dout = ch_rdata[ch_sel];
    assign IRQ  = |irq_vec;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multi_timer: scoreboard bench for multi_timer (N_CH=2) | Rev 1.0
// ----------------------------------------------------------------------------
module tb_multi_timer;

    localparam int N_CH = 2;
    localparam int K_DOUT = 0;
    localparam int K_IRQ  = 1;
    localparam int K_VEC  = 2;

    logic            clk;
    logic            reset;
    logic [31:2]     Addr;
    logic            WE;
    logic [31:0]     Din;
    logic [31:0]     Dout;
    logic            IRQ;
    logic [N_CH-1:0] irq_vec;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       n_cmp = 0;
    int       n_err = 0;

    multi_timer #(.N_CH(N_CH), .CNT_W(32), .PSC_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .IRQ     (IRQ),
        .irq_vec (irq_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Everything queued during a cycle is compared mid-cycle, away from the edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            sb_item_t it;
            it = sb.pop_front();
            case (it.kind)
                K_DOUT:  check_val(it.tag, Dout, it.exp);
                K_IRQ:   check_val(it.tag, {31'b0, IRQ}, it.exp);
                default: check_val(it.tag, {30'b0, irq_vec}, it.exp);
            endcase
        end
    end

    function automatic logic [31:2] aw(input int ch, input int rg);
        logic [29:0] a;
        a = 30'((ch << 2) | rg);
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] d);
        Addr = aw(ch, rg);
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic obs(input int ch, input int rg, input logic [31:0] e, input string tag);
        Addr = aw(ch, rg);
        sb.push_back('{tag, K_DOUT, e});
    endtask

    task automatic obs_irq(input logic e, input string tag);
        sb.push_back('{tag, K_IRQ, {31'b0, e}});
    endtask

    task automatic obs_vec(input logic [1:0] e, input string tag);
        sb.push_back('{tag, K_VEC, {30'b0, e}});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Din   = '0;
        Addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        obs(0, 0, 32'h0, "rst_ctrl0"); obs_irq(1'b0, "rst_irq"); obs_vec(2'b00, "rst_vec"); tick();
        obs(0, 2, 32'h0, "rst_count0"); tick();
        obs(1, 3, 32'h0, "rst_status1"); tick();

        // One-shot: ch0 PRESET=3, CTRL=0x9 at edge 0
        wr(0, 1, 32'd3);
        wr(0, 0, 32'h9);
        obs(0, 2, 32'd0, "os_c0"); tick();
        tick();
        for (int c = 2; c <= 5; c++) begin
            obs(0, 2, 32'(5 - c), $sformatf("os_count_c%0d", c));
            if (c == 4) obs_irq(1'b0, "os_irq_c4");
            if (c == 5) begin obs_irq(1'b1, "os_irq_c5"); obs_vec(2'b01, "os_vec_c5"); end
            tick();
        end
        obs(0, 0, 32'h8, "os_en_clear_c6"); tick();
        obs(0, 2, 32'd0, "os_count_hold_c7"); tick();
        obs(0, 3, 32'd1, "os_pend_c8"); tick();
        wr(0, 3, 32'd1);
        obs(0, 3, 32'd0, "os_w1c"); obs_irq(1'b0, "os_irq_clr"); tick();

        // Auto-reload: ch1 PRESET=2, CTRL=0xB
        wr(1, 1, 32'd2);
        wr(1, 0, 32'hB);
        tick_n(3);
        obs_vec(2'b00, "ar_vec_c3"); obs(1, 2, 32'd1, "ar_count_c3"); tick();
        obs_vec(2'b10, "ar_vec_c4"); obs_irq(1'b1, "ar_irq_c4");
        wr(1, 3, 32'd1);
        obs_vec(2'b00, "ar_vec_w1c"); tick();
        tick();
        obs(1, 2, 32'd2, "ar_reload_c7"); tick();
        obs(1, 2, 32'd1, "ar_count_c8"); tick();
        obs_vec(2'b10, "ar_vec_c9");
        wr(1, 0, 32'h0);
        tick();
        obs(1, 2, 32'd0, "ar_en0_no_reload"); tick();
        obs(1, 0, 32'd0, "ar_ctrl_off"); tick();
        wr(1, 3, 32'd1);

        // Prescaler: ch0 PRESET=2, CTRL=0x39
        wr(0, 1, 32'd2);
        wr(0, 0, 32'h39);
        for (int c = 0; c <= 10; c++) begin
            obs(0, 2, (c < 2) ? 32'd0 : (c < 6) ? 32'd2 : (c < 10) ? 32'd1 : 32'd0,
                $sformatf("psc_count_c%0d", c));
            if (c == 9)  obs_irq(1'b0, "psc_irq_c9");
            if (c == 10) obs_irq(1'b1, "psc_irq_c10");
            tick();
        end
        wr(0, 3, 32'd1);

        // Isolation: ch1 counts from 10 while ch0 PRESET is written 5 times
        wr(1, 1, 32'd10);
        wr(1, 0, 32'h1);
        tick_n(2);
        for (int k = 0; k < 5; k++) wr(0, 1, 32'(100 + k));
        obs(1, 2, 32'd5, "iso_ch1_count"); tick();
        obs(0, 1, 32'd104, "iso_ch0_preset"); tick();
        obs(0, 2, 32'd0, "iso_ch0_count"); tick();
        obs(0, 0, 32'h38, "iso_ch0_ctrl"); tick();
        obs(1, 2, 32'd1, "iso_ch1_c11"); tick();

        // Mask: ch1 pend with im=0 must not raise IRQ
        obs(1, 3, 32'd1, "mask_pend"); obs_irq(1'b0, "mask_irq"); obs_vec(2'b00, "mask_vec"); tick();
        wr(1, 3, 32'd0);
        obs(1, 3, 32'd1, "w1c_zero_noeffect"); tick();

        // Range: channels >= N_CH read 0 and ignore writes
        obs(7, 2, 32'd0, "range_ch7"); tick();
        wr(2, 1, 32'h55);
        obs(0, 1, 32'd104, "range_no_alias"); tick();
        obs(2, 1, 32'd0, "range_ch2_read"); tick();

        // Reset mid-count
        wr(1, 0, 32'h8);
        obs_irq(1'b1, "pre_rst_irq"); tick();
        wr(0, 1, 32'd50);
        wr(0, 0, 32'h9);
        tick_n(4);
        obs(0, 2, 32'd48, "pre_rst_count");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        obs(0, 2, 32'd0, "rst_mid_count"); obs_irq(1'b0, "rst_mid_irq"); obs_vec(2'b00, "rst_mid_vec"); tick();
        obs(0, 0, 32'd0, "rst_mid_ctrl"); tick();
        obs(0, 1, 32'd0, "rst_mid_preset"); tick();
        obs(1, 3, 32'd0, "rst_mid_status1"); tick();
        obs(0, 2, 32'd0, "rst_mid_idle"); tick();

        tick();
        check_val("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
